// File: rtl/wb_ram_arbiter.sv
// Round-robin Wishbone arbiter: shares one SRAM slave between NUM_MASTERS masters,
// routes ack/data to the granted master and terminates stalled cycles with err.
module wb_ram_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_MASTERS-1:0]      m_cyc_i,
    input  logic [NUM_MASTERS-1:0]      m_stb_i,
    input  logic [NUM_MASTERS-1:0]      m_we_i,
    input  logic [NUM_MASTERS*AW-1:0]   m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0]   m_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
    output logic [DW-1:0]               m_dat_o,
    output logic [NUM_MASTERS-1:0]      m_ack_o,
    output logic [NUM_MASTERS-1:0]      m_err_o,
    output logic                        s_cyc_o,
    output logic                        s_stb_o,
    output logic                        s_we_o,
    output logic [AW-1:0]               s_adr_o,
    output logic [DW-1:0]               s_dat_o,
    output logic [DW/8-1:0]             s_sel_o,
    input  logic [DW-1:0]               s_dat_i,
    input  logic                        s_ack_i,
    output logic [NUM_MASTERS-1:0]      grant_o
);

    localparam int SW = DW / 8;
    localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [NUM_MASTERS-1:0] GRANT_LSB = NUM_MASTERS'(1);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    logic [0:0]             state_r;
    logic [NUM_MASTERS-1:0] grant_r;
    logic [PW-1:0]          gidx_r;
    logic [PW-1:0]          ptr_r;
    logic [CW-1:0]          cnt_r;

    logic [NUM_MASTERS-1:0] req_s;
    logic                   pick_found_s;
    logic [PW-1:0]          pick_idx_s;
    logic                   active_s;
    logic                   g_cyc_s;
    logic                   g_stb_s;
    logic                   xfer_s;
    logic                   ack_s;
    logic                   tmo_s;
    logic [AW-1:0]          adr_a_s [NUM_MASTERS];
    logic [DW-1:0]          dat_a_s [NUM_MASTERS];
    logic [SW-1:0]          sel_a_s [NUM_MASTERS];

    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
        int t;
        t = int'(idx) + 1;
        if (t >= NUM_MASTERS) begin
            t = 0;
        end else begin
            t = t;
        end
        return t[PW-1:0];
    endfunction

    assign req_s   = m_cyc_i & m_stb_i;
    assign grant_o = grant_r;

    // Unpack flat master buses into per-master arrays
    always_comb begin
        for (int i = 0; i < NUM_MASTERS; i++) begin
            adr_a_s[i] = m_adr_i[i*AW +: AW];
            dat_a_s[i] = m_dat_i[i*DW +: DW];
            sel_a_s[i] = m_sel_i[i*SW +: SW];
        end
    end

    // Round-robin pick: first requester at or after ptr, with wrap
    always_comb begin : pick_c
        int            cand;
        logic [PW-1:0] cand_idx;
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        cand         = 0;
        cand_idx     = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand     = (int'(ptr_r) + i >= NUM_MASTERS) ? int'(ptr_r) + i - NUM_MASTERS
                                                        : int'(ptr_r) + i;
            cand_idx = cand[PW-1:0];
            if (!pick_found_s && req_s[cand_idx]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand_idx;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Slave-side mux and per-master ack/err routing for the granted master
    always_comb begin
        active_s = (state_r == ST_ACTIVE);
        g_cyc_s  = m_cyc_i[gidx_r];
        g_stb_s  = m_stb_i[gidx_r];
        xfer_s   = active_s & g_cyc_s & g_stb_s;
        ack_s    = xfer_s & s_ack_i;
        // Ack on the expiring cycle takes priority over the timeout
        tmo_s    = xfer_s & ~s_ack_i & (cnt_r == CNT_MAX);
        m_ack_o  = '0;
        m_err_o  = '0;
        m_ack_o[gidx_r] = ack_s;
        m_err_o[gidx_r] = tmo_s;
        if (active_s) begin
            s_cyc_o = g_cyc_s;
            s_stb_o = g_stb_s;
            s_we_o  = m_we_i[gidx_r];
            s_adr_o = adr_a_s[gidx_r];
            s_dat_o = dat_a_s[gidx_r];
            s_sel_o = sel_a_s[gidx_r];
            m_dat_o = s_dat_i;
        end else begin
            s_cyc_o = 1'b0;
            s_stb_o = 1'b0;
            s_we_o  = 1'b0;
            s_adr_o = '0;
            s_dat_o = '0;
            s_sel_o = '0;
            m_dat_o = '0;
        end
    end

    // Arbitration FSM, round-robin pointer and watchdog counter
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            grant_r <= '0;
            gidx_r  <= '0;
            ptr_r   <= '0;
            cnt_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= '0;
                    if (pick_found_s) begin
                        state_r <= ST_ACTIVE;
                        gidx_r  <= pick_idx_s;
                        grant_r <= GRANT_LSB << pick_idx_s;
                    end else begin
                        grant_r <= '0;
                    end
                end
                ST_ACTIVE: begin
                    if (!g_cyc_s || tmo_s) begin
                        state_r <= ST_IDLE;
                        grant_r <= '0;
                        ptr_r   <= next_idx(gidx_r);
                        cnt_r   <= '0;
                    end else if (ack_s || !xfer_s) begin
                        cnt_r <= '0;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    grant_r <= '0;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed bench for wb_ram_arbiter (2 masters, timeout 16): vector table plus
// hand-written sequences for hold, timeout, ack-at-timeout and mid-transfer reset.
module tb_wb_ram_arbiter;

    logic        clk_s = 1'b0;
    logic        rst_n_s;
    logic [1:0]  m_cyc_s, m_stb_s, m_we_s;
    logic [63:0] m_adr_s, m_dat_s;
    logic [7:0]  m_sel_s;
    logic [31:0] m_dat_o_s;
    logic [1:0]  m_ack_s, m_err_s, grant_s;
    logic        s_cyc_s, s_stb_s, s_we_s, s_ack_s;
    logic [31:0] s_adr_s, s_dat_o_s, s_dat_i_s;
    logic [3:0]  s_sel_s;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0]  cyc, stb, we;
        logic        ack;
        logic [31:0] sdat;
        logic [1:0]  e_grant;
        logic        e_scyc;
        logic [1:0]  e_ack, e_err;
        logic [31:0] e_adr, e_dat;
    } vec_t;

    vec_t tbl [17];

    wb_ram_arbiter #(.NUM_MASTERS(2), .AW(32), .DW(32), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk_s), .rst_ni(rst_n_s),
        .m_cyc_i(m_cyc_s), .m_stb_i(m_stb_s), .m_we_i(m_we_s),
        .m_adr_i(m_adr_s), .m_dat_i(m_dat_s), .m_sel_i(m_sel_s),
        .m_dat_o(m_dat_o_s), .m_ack_o(m_ack_s), .m_err_o(m_err_s),
        .s_cyc_o(s_cyc_s), .s_stb_o(s_stb_s), .s_we_o(s_we_s),
        .s_adr_o(s_adr_s), .s_dat_o(s_dat_o_s), .s_sel_o(s_sel_s),
        .s_dat_i(s_dat_i_s), .s_ack_i(s_ack_s), .grant_o(grant_s)
    );

    always #5 clk_s = ~clk_s;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs after the falling edge, leave time to settle
    task automatic drv(input logic [1:0] c, input logic [1:0] s, input logic [1:0] w,
                       input logic a, input logic [31:0] d);
        @(negedge clk_s);
        m_cyc_s   = c;
        m_stb_s   = s;
        m_we_s    = w;
        s_ack_s   = a;
        s_dat_i_s = d;
        #1;
    endtask

    initial begin
        rst_n_s   = 1'b0;
        m_cyc_s   = 2'b00;
        m_stb_s   = 2'b00;
        m_we_s    = 2'b00;
        m_adr_s   = {32'h0000_0200, 32'h0000_0100};
        m_dat_s   = {32'hB0B0_0001, 32'hA0A0_0001};
        m_sel_s   = 8'hFF;
        s_ack_s   = 1'b0;
        s_dat_i_s = 32'h0;

        //          cyc    stb    we     ack   sdat           grant scyc  ack    err    adr           dat
        tbl[0]  = '{2'b00, 2'b00, 2'b00, 1'b0, 32'h0,         2'b00, 1'b0, 2'b00, 2'b00, 32'h0,     32'h0};
        tbl[1]  = '{2'b01, 2'b01, 2'b00, 1'b0, 32'h0,         2'b00, 1'b0, 2'b00, 2'b00, 32'h0,     32'h0};
        tbl[2]  = '{2'b01, 2'b01, 2'b00, 1'b0, 32'h0,         2'b01, 1'b1, 2'b00, 2'b00, 32'h100,   32'h0};
        tbl[3]  = '{2'b01, 2'b01, 2'b00, 1'b0, 32'h0,         2'b01, 1'b1, 2'b00, 2'b00, 32'h100,   32'h0};
        tbl[4]  = '{2'b01, 2'b01, 2'b00, 1'b1, 32'hDEADBEEF,  2'b01, 1'b1, 2'b01, 2'b00, 32'h100,   32'hDEADBEEF};
        tbl[5]  = '{2'b00, 2'b00, 2'b00, 1'b1, 32'h0,         2'b01, 1'b0, 2'b00, 2'b00, 32'h100,   32'h0};
        tbl[6]  = '{2'b00, 2'b00, 2'b00, 1'b0, 32'h0,         2'b00, 1'b0, 2'b00, 2'b00, 32'h0,     32'h0};
        tbl[7]  = '{2'b11, 2'b11, 2'b00, 1'b0, 32'h0,         2'b00, 1'b0, 2'b00, 2'b00, 32'h0,     32'h0};
        tbl[8]  = '{2'b11, 2'b11, 2'b00, 1'b1, 32'h11111111,  2'b10, 1'b1, 2'b10, 2'b00, 32'h200,   32'h11111111};
        tbl[9]  = '{2'b01, 2'b01, 2'b00, 1'b0, 32'h0,         2'b10, 1'b0, 2'b00, 2'b00, 32'h200,   32'h0};
        tbl[10] = '{2'b11, 2'b11, 2'b00, 1'b0, 32'h0,         2'b00, 1'b0, 2'b00, 2'b00, 32'h0,     32'h0};
        tbl[11] = '{2'b11, 2'b11, 2'b00, 1'b1, 32'h22222222,  2'b01, 1'b1, 2'b01, 2'b00, 32'h100,   32'h22222222};
        tbl[12] = '{2'b10, 2'b10, 2'b00, 1'b0, 32'h0,         2'b01, 1'b0, 2'b00, 2'b00, 32'h100,   32'h0};
        tbl[13] = '{2'b11, 2'b11, 2'b00, 1'b0, 32'h0,         2'b00, 1'b0, 2'b00, 2'b00, 32'h0,     32'h0};
        tbl[14] = '{2'b11, 2'b11, 2'b00, 1'b1, 32'h33333333,  2'b10, 1'b1, 2'b10, 2'b00, 32'h200,   32'h33333333};
        tbl[15] = '{2'b00, 2'b00, 2'b00, 1'b0, 32'h0,         2'b10, 1'b0, 2'b00, 2'b00, 32'h200,   32'h0};
        tbl[16] = '{2'b00, 2'b00, 2'b00, 1'b1, 32'h44444444,  2'b00, 1'b0, 2'b00, 2'b00, 32'h0,     32'h0};

        repeat (2) @(posedge clk_s);
        @(negedge clk_s);
        rst_n_s = 1'b1;

        // Single read by master 0, then alternating grants with both requesting
        for (int i = 0; i < 17; i++) begin
            drv(tbl[i].cyc, tbl[i].stb, tbl[i].we, tbl[i].ack, tbl[i].sdat);
            chk($sformatf("row%0d grant", i), 32'(grant_s),   32'(tbl[i].e_grant));
            chk($sformatf("row%0d s_cyc", i), 32'(s_cyc_s),   32'(tbl[i].e_scyc));
            chk($sformatf("row%0d ack", i),   32'(m_ack_s),   32'(tbl[i].e_ack));
            chk($sformatf("row%0d err", i),   32'(m_err_s),   32'(tbl[i].e_err));
            chk($sformatf("row%0d s_adr", i), s_adr_s,        tbl[i].e_adr);
            chk($sformatf("row%0d m_dat", i), m_dat_o_s,      tbl[i].e_dat);
        end

        // Master 1 holds cyc over three writes while master 0 waits
        drv(2'b10, 2'b10, 2'b10, 1'b0, 32'h0);
        chk("hold idle grant", 32'(grant_s), 32'h0);
        m_sel_s[7:4] = 4'hF;
        drv(2'b11, 2'b11, 2'b10, 1'b1, 32'h0);
        chk("hold w1 grant", 32'(grant_s), 32'h2);
        chk("hold w1 sel",   32'(s_sel_s), 32'hF);
        chk("hold w1 we",    32'(s_we_s),  32'h1);
        chk("hold w1 sdat",  s_dat_o_s,    32'hB0B0_0001);
        chk("hold w1 ack",   32'(m_ack_s), 32'h2);
        m_sel_s[7:4] = 4'h3;
        drv(2'b11, 2'b11, 2'b10, 1'b1, 32'h0);
        chk("hold w2 grant", 32'(grant_s), 32'h2);
        chk("hold w2 sel",   32'(s_sel_s), 32'h3);
        chk("hold w2 ack",   32'(m_ack_s), 32'h2);
        m_sel_s[7:4] = 4'h1;
        drv(2'b11, 2'b11, 2'b10, 1'b1, 32'h0);
        chk("hold w3 grant", 32'(grant_s), 32'h2);
        chk("hold w3 sel",   32'(s_sel_s), 32'h1);
        chk("hold w3 ack",   32'(m_ack_s), 32'h2);
        drv(2'b01, 2'b01, 2'b00, 1'b0, 32'h0);
        chk("hold drop grant", 32'(grant_s), 32'h2);
        chk("hold drop s_cyc", 32'(s_cyc_s), 32'h0);
        drv(2'b01, 2'b01, 2'b00, 1'b0, 32'h0);
        chk("hold rearb grant", 32'(grant_s), 32'h0);
        drv(2'b01, 2'b01, 2'b00, 1'b1, 32'h0);
        chk("hold m0 grant", 32'(grant_s), 32'h1);
        chk("hold m0 ack",   32'(m_ack_s), 32'h1);
        drv(2'b00, 2'b00, 2'b00, 1'b0, 32'h0);

        // Slave never acks master 0; master 1 joins and gets the bus afterwards
        drv(2'b01, 2'b01, 2'b00, 1'b0, 32'h0);
        chk("tmo idle grant", 32'(grant_s), 32'h0);
        for (int k = 1; k <= 16; k++) begin
            drv(2'b11, 2'b11, 2'b00, 1'b0, 32'h0);
            chk($sformatf("tmo k%0d grant", k), 32'(grant_s), 32'h1);
            chk($sformatf("tmo k%0d err", k),   32'(m_err_s), (k == 16) ? 32'h1 : 32'h0);
            chk($sformatf("tmo k%0d ack", k),   32'(m_ack_s), 32'h0);
        end
        drv(2'b11, 2'b11, 2'b00, 1'b0, 32'h0);
        chk("tmo after grant", 32'(grant_s), 32'h0);
        chk("tmo after s_cyc", 32'(s_cyc_s), 32'h0);
        chk("tmo after s_stb", 32'(s_stb_s), 32'h0);
        chk("tmo after err",   32'(m_err_s), 32'h0);
        drv(2'b11, 2'b11, 2'b00, 1'b0, 32'h0);
        chk("tmo next grant", 32'(grant_s), 32'h2);
        chk("tmo next s_adr", s_adr_s,      32'h200);
        drv(2'b00, 2'b00, 2'b00, 1'b0, 32'h0);

        // Ack arrives exactly on the expiring wait cycle
        drv(2'b01, 2'b01, 2'b00, 1'b0, 32'h0);
        for (int k = 1; k <= 15; k++) begin
            drv(2'b01, 2'b01, 2'b00, 1'b0, 32'h0);
            chk($sformatf("race k%0d err", k), 32'(m_err_s), 32'h0);
        end
        drv(2'b01, 2'b01, 2'b00, 1'b1, 32'hCAFE_F00D);
        chk("race ack",   32'(m_ack_s), 32'h1);
        chk("race err",   32'(m_err_s), 32'h0);
        chk("race m_dat", m_dat_o_s,    32'hCAFE_F00D);
        drv(2'b01, 2'b01, 2'b00, 1'b0, 32'h0);
        chk("race hold grant", 32'(grant_s), 32'h1);
        chk("race hold err",   32'(m_err_s), 32'h0);
        drv(2'b00, 2'b00, 2'b00, 1'b0, 32'h0);

        // Reset while master 1 waits; late ack ignored, arbitration restarts at 0
        drv(2'b10, 2'b10, 2'b00, 1'b0, 32'h0);
        drv(2'b10, 2'b10, 2'b00, 1'b0, 32'h0);
        chk("rst pre grant", 32'(grant_s), 32'h2);
        drv(2'b10, 2'b10, 2'b00, 1'b0, 32'h0);
        @(negedge clk_s);
        rst_n_s = 1'b0;
        #1;
        @(negedge clk_s);
        rst_n_s   = 1'b1;
        m_cyc_s   = 2'b11;
        m_stb_s   = 2'b11;
        s_ack_s   = 1'b1;
        s_dat_i_s = 32'h5555_5555;
        #1;
        chk("rst grant", 32'(grant_s), 32'h0);
        chk("rst s_cyc", 32'(s_cyc_s), 32'h0);
        chk("rst s_stb", 32'(s_stb_s), 32'h0);
        chk("rst s_adr", s_adr_s,      32'h0);
        chk("rst ack",   32'(m_ack_s), 32'h0);
        chk("rst err",   32'(m_err_s), 32'h0);
        chk("rst m_dat", m_dat_o_s,    32'h0);
        drv(2'b11, 2'b11, 2'b00, 1'b0, 32'h0);
        chk("rst restart grant", 32'(grant_s), 32'h1);
        drv(2'b00, 2'b00, 2'b00, 1'b0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
